sopc_top_ram_copy_master: RTL and testbench
===========================================

# sopc_top_ram_copy_master

Avalon-MM master engine that drives the second (s2) port of the 64 x 32-bit dual-port on-chip memory in the SOPC top. Two modes:
- **Copy:** moves a block of words from a source to a destination word address in that memory.
- **Fill:** writes a constant pattern over a block of words.

It is the initiator for that memory port. It runs at the memory's fixed, non-waitrequest read latency and relieves the processor on port s1 of bulk moves.

## Interface
Parameters:
- ADDR_W, 6, word address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 32, data width; byteenable width is DATA_W/8
- READ_LATENCY, 1, cycles from read command to valid m_readdata (allowed 1..4)

Ports:
- clk  in  1  single clock for all logic and the memory port
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request, sampled only in IDLE
- fill_en  in  1  sampled with start: 1 = fill, 0 = copy
- src_addr  in  ADDR_W  first source word address (copy only)
- dst_addr  in  ADDR_W  first destination word address
- length  in  ADDR_W+1  word count, 0..2^ADDR_W
- fill_data  in  DATA_W  pattern for fill mode, sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- words_done  out  ADDR_W+1  words written since last accepted start
- m_address  out  ADDR_W  memory word address
- m_byteenable  out  DATA_W/8  constant all-ones
- m_chipselect  out  1  command valid for this cycle
- m_write  out  1  1 = write command, 0 = read (only meaningful with m_chipselect)
- m_writedata  out  DATA_W  write data
- m_clken  out  1  constant 1
- m_readdata  in  DATA_W  read data, valid READ_LATENCY cycles after read command

## Operation
- **Accepting a start:** start in IDLE latches src, dst, length, fill_en and fill_data, and clears words_done. start outside IDLE is ignored.
- **States and transitions:**
  - IDLE -> DONE if length = 0.
  - IDLE -> WRITE if fill_en = 1.
  - IDLE -> READ otherwise.
  - READ: chipselect=1, write=0, address=src pointer; -> WAIT.
  - WAIT: lasts exactly READ_LATENCY cycles. In its last cycle, m_readdata is captured into the data buffer; -> WRITE.
  - WRITE: chipselect=1, write=1, address=dst pointer, writedata = buffer (copy) or fill_data (fill). Increments words_done and both pointers, which wrap mod 2^ADDR_W.
    - -> DONE if this was the last word.
    - else -> READ (copy) or WRITE (fill).
  - DONE: done=1 for one cycle; -> IDLE.
- **Transfer order:** one word at a time, ascending addresses. Overlapping regions are copied in that order with no overlap correction; with dst = src+1, source words are overwritten before they are read.
- **Outputs outside READ/WRITE:**
  - m_chipselect = 0 and m_write = 0.
  - m_address and m_writedata hold their last values.
- **Width rule:** words_done saturates naturally at length, which is ≤ 2^ADDR_W, so ADDR_W+1 bits suffice.
- **Reset (any time, including mid-transfer):** aborts immediately, returns to IDLE, no further bus commands. Memory contents already written stay written.

## Timing
- **Reset values:** busy=0, done=0, words_done=0, m_address=0, m_writedata=0, m_chipselect=0, m_write=0, m_byteenable=all ones, m_clken=1.
- **Cycle numbering:** start high in cycle 0; busy is first high in cycle 1.
- **Copy, L words:** 2+READ_LATENCY cycles per word.
  - Word k: READ in cycle 1+k(2+RL), WRITE in cycle (k+1)(2+RL).
  - done in cycle L(2+RL)+1.
  - With RL=1: writes at cycles 3, 6, 9…
- **Fill, L words:** one word per cycle, WRITE in cycles 1..L, done in cycle L+1.
- **Length 0:** done in cycle 1 with no bus command; busy is high in cycle 1 only.
- **Back-to-back:** a start in the cycle after done is accepted.
- **Bus protocol:** no waitrequest; every command completes in its own cycle.

## Test plan
- **Reset values:** assert reset asynchronously mid-cycle -> all outputs at the reset values immediately; byteenable = 4'hF, clken = 1.
- **Copy with RL=1:** memory model holds A at 5, B at 6, C at 7; copy src=5 dst=20 len=3 -> reads at 5/6/7 in cycles 1/4/7, writes of A/B/C to 20/21/22 in cycles 3/6/9, done in cycle 10, words_done = 3.
- **Fill with wrap:** fill dst=62 len=4 fill_data=32'hDEADBEEF -> writes to 62, 63, 0, 1 in cycles 1-4, done in cycle 5.
- **Zero length and ignored start:** len=0 -> done in cycle 1, no chipselect. Separately, pulse start again while busy during a copy -> ignored; original transfer completes unchanged.
- **Reset mid-copy:** reset during the WAIT of word 2 -> no further chipselect, busy=0, done never pulses. A subsequent start runs normally.
- **Longer latency:** READ_LATENCY=3, copy len=2 -> write cycles 5 and 10, done in cycle 11, data captured in the correct cycle (model drives garbage before latency expires).

Source files
------------

// File: rtl/sopc_top_ram_copy_master.sv
// Avalon-MM copy/fill engine for port s2 of the 64 x 32 dual-port on-chip RAM.
// It moves one word at a time, ascending, at the RAM's fixed read latency.
// All bus outputs are registered, and they hold their values between commands.
module sopc_top_ram_copy_master #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                fill_en,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   fill_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words_done,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

  // Index of the last WAIT cycle; the read data is valid in that cycle.
  localparam logic [2:0] WaitLast = 3'(READ_LATENCY - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W:0]     len_q;
  logic                fill_q;
  logic [DATA_W-1:0]   fill_data_q;
  logic [2:0]          wait_q;
  logic [ADDR_W:0]     words_done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cs_q;
  logic                wr_q;
  logic                done_q;
  logic [ADDR_W:0]     words_inc;

  assign words_inc = words_done_q + 1'b1;

  // Transfer FSM; bus outputs are set on the edge that enters READ or WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      fill_q       <= 1'b0;
      fill_data_q  <= '0;
      wait_q       <= '0;
      words_done_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cs_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            src_q        <= src_addr;
            dst_q        <= dst_addr;
            len_q        <= length;
            fill_q       <= fill_en;
            fill_data_q  <= fill_data;
            words_done_q <= '0;
            if (length == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (fill_en) begin
              state_q <= StWrite;
              cs_q    <= 1'b1;
              wr_q    <= 1'b1;
              addr_q  <= dst_addr;
              wdata_q <= fill_data;
            end else begin
              state_q <= StRead;
              cs_q    <= 1'b1;
              addr_q  <= src_addr;
            end
          end
        end
        StRead: begin
          state_q <= StWait;
          wait_q  <= '0;
        end
        StWait: begin
          if (wait_q == WaitLast) begin
            state_q <= StWrite;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= dst_q;
            wdata_q <= m_readdata;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end
        StWrite: begin
          words_done_q <= words_inc;
          src_q        <= src_q + 1'b1;
          dst_q        <= dst_q + 1'b1;
          if (words_inc == len_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (fill_q) begin
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= dst_q + 1'b1;
            wdata_q <= fill_data_q;
          end else begin
            state_q <= StRead;
            cs_q    <= 1'b1;
            addr_q  <= src_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign words_done   = words_done_q;
  assign m_address    = addr_q;
  assign m_writedata  = wdata_q;
  assign m_chipselect = cs_q;
  assign m_write      = wr_q;
  assign m_byteenable = '1;
  assign m_clken      = 1'b1;

endmodule

// File: tb/tb_sopc_top_ram_copy_master.sv
// Bench for the RAM copy/fill master: two instances (read latency 1 and 3), each with
// its own RAM model, checked against a word-by-word reference of the transfer.
module tb_sopc_top_ram_copy_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0, fill_en = 1'b0;
  logic [5:0]  src_addr = '0, dst_addr = '0;
  logic [6:0]  length = '0;
  logic [31:0] fill_data = '0;

  logic        busy1, done1, cs1, wr1, clken1, busy3, done3, cs3, wr3, clken3;
  logic [6:0]  wd1, wd3;
  logic [5:0]  addr1, addr3;
  logic [3:0]  be1, be3;
  logic [31:0] wdata1, wdata3, rdata1, rdata3;

  always #5 clk = ~clk;

  sopc_top_ram_copy_master #(.ADDR_W(6), .DATA_W(32), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .fill_en(fill_en), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .fill_data(fill_data), .busy(busy1), .done(done1),
    .words_done(wd1), .m_address(addr1), .m_byteenable(be1), .m_chipselect(cs1),
    .m_write(wr1), .m_writedata(wdata1), .m_clken(clken1), .m_readdata(rdata1)
  );

  sopc_top_ram_copy_master #(.ADDR_W(6), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .fill_en(fill_en), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .fill_data(fill_data), .busy(busy3), .done(done3),
    .words_done(wd3), .m_address(addr3), .m_byteenable(be3), .m_chipselect(cs3),
    .m_write(wr3), .m_writedata(wdata3), .m_clken(clken3), .m_readdata(rdata3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: read data is valid only exactly READ_LATENCY cycles after the read.
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic        mem_init = 1'b0;
  logic [31:0] seed = 32'h1234_5678;
  logic        v1 = 1'b0;
  logic [2:0]  v3 = 3'b000;
  logic [31:0] d1;
  logic [31:0] d3 [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= seed ^ (i * 32'h9E37_79B1);
        mem3[i] <= ~seed ^ (i * 32'h85EB_CA77);
      end
    end else begin
      if (cs1 === 1'b1 && wr1 === 1'b1) mem1[addr1] <= wdata1;
      if (cs3 === 1'b1 && wr3 === 1'b1) mem3[addr3] <= wdata3;
    end
    v1    <= (cs1 === 1'b1 && wr1 === 1'b0);
    d1    <= mem1[addr1];
    v3    <= {v3[1:0], (cs3 === 1'b1 && wr3 === 1'b0)};
    d3[0] <= mem3[addr3];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end

  assign rdata1 = v1 ? d1 : (32'hBAD0_0000 ^ 32'(cyc));
  assign rdata3 = v3[2] ? d3[2] : (32'hBAD0_0000 ^ 32'(cyc));

  // Bus monitors: every chipselect cycle and every done pulse.
  typedef struct {int c; bit wr; logic [5:0] a; logic [31:0] d;} cmd_t;
  cmd_t log1[$];
  cmd_t log3[$];
  cmd_t mon_e;
  int   done_cnt1 = 0;

  always @(negedge clk) begin
    if (cs1 === 1'b1) begin
      mon_e.c = cyc; mon_e.wr = wr1; mon_e.a = addr1; mon_e.d = wdata1;
      log1.push_back(mon_e);
    end
    if (cs3 === 1'b1) begin
      mon_e.c = cyc; mon_e.wr = wr3; mon_e.a = addr3; mon_e.d = wdata3;
      log3.push_back(mon_e);
    end
    if (done1 === 1'b1) done_cnt1++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] pack_cmd(input cmd_t e);
    return {8'(e.c), 7'd0, e.wr, 10'd0, e.a, (e.wr ? e.d : 32'd0)};
  endfunction

  // One transfer: start, optional ignored start at cycle 'poke', then compare done cycle,
  // words_done, the full command log and the final RAM image against the reference.
  task automatic run(input int rl, input bit fl, input int src, input int dst, input int len,
                     input logic [31:0] fd, input int poke, input int exp_done,
                     input string nm);
    logic [31:0] mm [64];
    cmd_t        exp_q[$];
    cmd_t        got[$];
    cmd_t        e;
    logic [31:0] rd;
    int          t0, r, dc, wdv, bad;
    bit          seen;
    @(posedge clk); #1;
    if (rl == 1) begin mm = mem1; log1.delete(); end
    else begin mm = mem3; log3.delete(); end
    fill_en = fl; src_addr = 6'(src); dst_addr = 6'(dst); length = 7'(len); fill_data = fd;
    if (rl == 1) start1 = 1'b1; else start3 = 1'b1;
    t0 = cyc; seen = 1'b0; dc = -1; wdv = -1;
    for (int k = 0; k < 800 && !seen; k++) begin
      @(negedge clk);
      r = cyc - t0;
      if (r == 1) begin start1 = 1'b0; start3 = 1'b0; end
      if (poke > 1 && r == poke) begin
        src_addr = ~src_addr; dst_addr = dst_addr ^ 6'h15; length = 7'd1; fill_en = ~fill_en;
        if (rl == 1) start1 = 1'b1; else start3 = 1'b1;
      end
      if (poke > 1 && r == poke + 1) begin start1 = 1'b0; start3 = 1'b0; end
      if ((rl == 1 ? done1 : done3) === 1'b1) begin
        seen = 1'b1; dc = r;
        wdv = (rl == 1) ? int'(wd1) : int'(wd3);
      end
    end
    start1 = 1'b0; start3 = 1'b0;
    chk({nm, " done_cycle"}, 64'(dc), 64'(exp_done));
    chk({nm, " words_done"}, 64'(wdv), 64'(len));
    for (int k = 0; k < len; k++) begin
      if (fl) begin
        e.c = k + 1; e.wr = 1'b1; e.a = 6'(dst + k); e.d = fd; exp_q.push_back(e);
        mm[(dst + k) % 64] = fd;
      end else begin
        rd = mm[(src + k) % 64];
        e.c = 1 + k * (2 + rl); e.wr = 1'b0; e.a = 6'(src + k); e.d = 32'd0;
        exp_q.push_back(e);
        e.c = (k + 1) * (2 + rl); e.wr = 1'b1; e.a = 6'(dst + k); e.d = rd;
        exp_q.push_back(e);
        mm[(dst + k) % 64] = rd;
      end
    end
    if (rl == 1) got = log1; else got = log3;
    chk({nm, " cmd_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      e = got[i]; e.c = e.c - t0;
      chk({nm, " cmd"}, pack_cmd(e), pack_cmd(exp_q[i]));
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (rl == 1 && mem1[i] !== mm[i]) bad++;
      if (rl == 3 && mem3[i] !== mm[i]) bad++;
    end
    chk({nm, " ram_image_bad_words"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    int rl; bit fl; int src; int dst; int len; logic [31:0] fd; int poke; int exp_done;
    string nm;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0, dc0, rl, fl, len, ed;

    vecs[0] = '{1, 1'b0, 5, 20, 3, 32'h0, 0, 10, "copy_rl1"};
    vecs[1] = '{1, 1'b1, 0, 62, 4, 32'hDEAD_BEEF, 0, 5, "fill_wrap"};
    vecs[2] = '{1, 1'b0, 9, 33, 0, 32'h0, 0, 1, "zero_len"};
    vecs[3] = '{1, 1'b0, 10, 11, 4, 32'h0, 4, 13, "overlap_ignored_start"};
    vecs[4] = '{3, 1'b0, 30, 40, 2, 32'h0, 0, 11, "copy_rl3"};
    vecs[5] = '{1, 1'b1, 0, 7, 64, 32'hA5A5_0F0F, 0, 65, "fill_full"};
    vecs[6] = '{1, 1'b0, 63, 0, 2, 32'h0, 0, 7, "copy_wrap"};

    // Asynchronous reset mid-cycle: outputs must settle without a clock edge.
    #23 reset = 1'b1;
    #1;
    chk("rst busy", 64'(busy1), 64'd0);
    chk("rst done", 64'(done1), 64'd0);
    chk("rst words_done", 64'(wd1), 64'd0);
    chk("rst m_address", 64'(addr1), 64'd0);
    chk("rst m_writedata", 64'(wdata1), 64'd0);
    chk("rst m_chipselect", 64'(cs1), 64'd0);
    chk("rst m_write", 64'(wr1), 64'd0);
    chk("rst m_byteenable", 64'(be1), 64'hF);
    chk("rst m_clken", 64'(clken1), 64'd1);
    chk("rst rl3 outputs", {busy3, done3, cs3, wr3, clken3, be3, wd3, addr3, wdata3},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 7'd0, 6'd0, 32'd0});

    seed = $urandom;
    @(posedge clk); #1 mem_init = 1'b1;
    @(posedge clk); #1 mem_init = 1'b0;
    reset = 1'b0;

    foreach (vecs[i])
      run(vecs[i].rl, vecs[i].fl, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fd,
          vecs[i].poke, vecs[i].exp_done, vecs[i].nm);

    // Reset during the WAIT of the third word: nothing further on the bus, no done.
    @(posedge clk); #1;
    fill_en = 1'b0; src_addr = 6'd5; dst_addr = 6'd20; length = 7'd3; start1 = 1'b1;
    t0 = cyc;
    @(posedge clk); #1 start1 = 1'b0;
    while (cyc - t0 < 8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset busy", 64'(busy1), 64'd0);
    chk("midreset chipselect", 64'(cs1), 64'd0);
    log1.delete();
    dc0 = done_cnt1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midreset cmds_after", 64'(log1.size()), 64'd0);
    chk("midreset done_pulses", 64'(done_cnt1 - dc0), 64'd0);
    run(1, 1'b0, 40, 50, 5, 32'h0, 0, 16, "after_reset");

    // Randomized back-to-back transfers.
    for (int i = 0; i < 24; i++) begin
      rl  = (i % 4 == 3) ? 3 : 1;
      fl  = int'($urandom_range(0, 1));
      len = int'($urandom_range(0, 64));
      ed  = (len == 0) ? 1 : (fl != 0) ? len + 1 : len * (2 + rl) + 1;
      run(rl, fl[0], int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), len,
          $urandom, 0, ed, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
